// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage and its consumers.
package if_pkg;

   localparam int          XLEN_DEF  = 32;
   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0]         instr;
      logic [XLEN_DEF-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Small synchronous FIFO between IMEM response and decode; flush beats push/pop.
module if_fetch_queue
   import if_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = $bits(fetch_entry_t)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] storage [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != FULL) || do_pop);
   assign head    = storage[rd_ptr];

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: entry storage is deliberately not reset; count alone defines validity.
   always_ff @(posedge clk) begin
      if (do_push) storage[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Pipelined instruction fetch: PC register, synchronous IMEM, redirect/flush
// and a fetch queue presenting {instr, pc, pc+4} to decode.
module if_fetch_unit
   import if_pkg::*;
#(
   parameter int              XLEN       = XLEN_DEF,
   parameter int              IMEM_DEPTH = 256,
   parameter int              FQ_DEPTH   = 2,
   parameter logic [XLEN-1:0] RESET_PC   = '0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          redirect_valid,
   input  logic [XLEN-1:0]               redirect_pc,
   input  logic                          id_ready,
   output logic                          if_valid,
   output logic [31:0]                   if_instr,
   output logic [XLEN-1:0]               if_pc,
   output logic [XLEN-1:0]               if_pc_4,
   output logic [$clog2(FQ_DEPTH):0]     if_count,
   input  logic                          imem_we,
   input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
   input  logic [31:0]                   imem_wdata
);

   localparam int IDX_W = $clog2(IMEM_DEPTH);
   localparam int CNT_W = $clog2(FQ_DEPTH) + 1;
   localparam int OCC_W = CNT_W + 1;
   localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(FQ_DEPTH);

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
   } entry_t;

   logic [XLEN-1:0]  pc_q;
   logic [XLEN-1:0]  inflight_pc_q;
   logic             inflight_q;
   logic [31:0]      imem [IMEM_DEPTH];
   logic [31:0]      rdata_q;
   logic [IDX_W-1:0] rd_idx;

   logic             issue;
   logic             push;
   logic             pop;
   logic [OCC_W-1:0] occupancy;
   logic [CNT_W-1:0] count;
   entry_t           push_entry;
   entry_t           head;
   logic             unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];
   assign rd_idx               = pc_q[IDX_W+1:2];

   // An entry popped this cycle frees its slot for the fetch issued this
   // cycle; without that credit a 2-deep queue could not sustain 1 instr/cycle.
   // NOTE: every always_comb output gets a default first, so no latch is inferred.
   always_comb begin
      pop       = 1'b0;
      push      = 1'b0;
      issue     = 1'b0;
      occupancy = '0;
      pop       = if_valid && id_ready;
      push      = inflight_q && !redirect_valid;
      occupancy = OCC_W'(count) + OCC_W'(inflight_q) - OCC_W'(pop);
      issue     = !redirect_valid && (occupancy < OCC_MAX);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else if (redirect_valid) begin
         pc_q          <= {redirect_pc[XLEN-1:2], 2'b00};
         inflight_q    <= 1'b0;
      end else begin
         inflight_q    <= issue;
         if (issue) begin
            pc_q          <= pc_q + XLEN'(4);
            inflight_pc_q <= pc_q;
         end
      end
   end

   // Reading every cycle is safe: pc_q only moves on issue, so rdata_q always
   // holds the word of the fetch that is in flight. Same-word writes read old data.
   always_ff @(posedge clk) begin
      if (imem_we) imem[imem_waddr] <= imem_wdata;
      rdata_q <= imem[rd_idx];
   end

   assign push_entry = '{instr: rdata_q, pc: inflight_pc_q};

   if_fetch_queue #(
      .DEPTH (FQ_DEPTH),
      .WIDTH ($bits(entry_t))
   ) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop && !redirect_valid),
      .head      (head),
      .count     (count)
   );

   assign if_valid = (count != '0);
   assign if_count = count;
   assign if_instr = if_valid ? head.instr : 32'h0;
   assign if_pc    = if_valid ? head.pc : '0;
   assign if_pc_4  = if_valid ? head.pc + XLEN'(4) : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit with default parameters.
module tb_if_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_4;
   logic [1:0]  if_count;
   logic        imem_we;
   logic [7:0]  imem_waddr;
   logic [31:0] imem_wdata;

   int total = 0;
   int bad   = 0;

   if_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_pc_4        (if_pc_4),
      .if_count       (if_count),
      .imem_we        (imem_we),
      .imem_waddr     (imem_waddr),
      .imem_wdata     (imem_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic check_head(input string tag, input logic [31:0] pc);
      check({tag, "_valid"}, 64'(if_valid), 64'd1);
      check({tag, "_pc"},    64'(if_pc),    64'(pc));
      check({tag, "_instr"}, 64'(if_instr), 64'(32'h1000_0000 + {24'h0, pc[9:2]}));
      check({tag, "_pc4"},   64'(if_pc_4),  64'(pc + 32'd4));
   endtask

   initial begin
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      id_ready       = 1'b0;
      imem_we        = 1'b0;
      imem_waddr     = '0;
      imem_wdata     = '0;

      // program load under reset: word i = 0x1000_0000 + i
      for (int i = 0; i < 256; i++) begin
         imem_we    = 1'b1;
         imem_waddr = 8'(i);
         imem_wdata = 32'h1000_0000 + 32'(i);
         tick();
      end
      imem_we = 1'b0;
      tick();

      check("rst_valid", 64'(if_valid), 64'd0);
      check("rst_count", 64'(if_count), 64'd0);
      check("rst_instr", 64'(if_instr), 64'd0);
      check("rst_pc",    64'(if_pc),    64'd0);
      check("rst_pc4",   64'(if_pc_4),  64'd0);

      // sequential fetch
      id_ready = 1'b1;
      rst_n    = 1'b1;
      tick();
      check("seq_edge1_valid", 64'(if_valid), 64'd0);
      tick();
      check_head("seq0", 32'h0);
      for (int i = 1; i < 8; i++) begin
         tick();
         check_head("seq", 32'(4 * i));
      end

      // backpressure from a fresh reset
      rst_n    = 1'b0;
      id_ready = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check("bp_count_sat", 64'(if_count), 64'd2);
      check_head("bp_hold", 32'h0);
      id_ready = 1'b1;
      tick();
      check_head("bp_rel4", 32'h4);
      check("bp_rel_count", 64'(if_count), 64'd1);
      tick();
      check_head("bp_rel8", 32'h8);

      // redirect while pc 8 queued and pc 0xC in flight
      redirect_valid = 1'b1;
      redirect_pc    = 32'h14;
      tick();
      redirect_valid = 1'b0;
      check("rd_flush_valid", 64'(if_valid), 64'd0);
      check("rd_flush_count", 64'(if_count), 64'd0);
      tick();
      check("rd_lat_valid", 64'(if_valid), 64'd0);
      tick();
      check_head("rd_t14", 32'h14);
      tick();
      check_head("rd_t18", 32'h18);

      // fill queue, then redirect with pop requested
      id_ready = 1'b0;
      tick();
      tick();
      check("sim_full", 64'(if_count), 64'd2);
      id_ready       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h22;
      tick();
      redirect_valid = 1'b0;
      check("sim_count", 64'(if_count), 64'd0);
      check("sim_valid", 64'(if_valid), 64'd0);
      tick();
      tick();
      check_head("sim_t20", 32'h20);

      // wrap at the top of the address space
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      tick();
      tick();
      check("wrap_valid", 64'(if_valid), 64'd1);
      check("wrap_pc",    64'(if_pc),    64'hFFFF_FFFC);
      check("wrap_instr", 64'(if_instr), 64'h1000_00FF);
      check("wrap_pc4",   64'(if_pc_4),  64'd0);
      tick();
      check_head("wrap_next", 32'h0);

      // reset mid-stream
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid_rst_valid", 64'(if_valid), 64'd0);
      check("mid_rst_count", 64'(if_count), 64'd0);
      check("mid_rst_pc",    64'(if_pc),    64'd0);
      tick();
      check("mid_rst_lat", 64'(if_valid), 64'd0);
      tick();
      check_head("mid_rst_0", 32'h0);
      tick();
      check_head("mid_rst_4", 32'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
